// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier datapath and its
// downstream frame accumulator.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int DEF_PROD_W = 9;
    localparam int DEF_ACC_W  = 16;

    // Widest accumulator (plus guard bit) the saturate helper can handle.
    localparam int SAT_MAX_W = 64;

    typedef logic [SAT_MAX_W-1:0] sat_word_t;

    typedef struct packed {
        logic      ovf;
        sat_word_t value;
    } sat_result_t;

    // sum carries an (acc_w+1)-bit two's-complement value, sign-extended.
    // Overflow shows up as a disagreement between the guard bit and the
    // acc_w-bit sign bit; the clamp direction follows the guard bit.
    function automatic sat_result_t saturate(input sat_word_t  sum,
                                             input logic [5:0] acc_w);
        sat_result_t res;
        sat_word_t   max_pos;
        max_pos = (SAT_MAX_W'(1) << (acc_w - 6'd1)) - SAT_MAX_W'(1);
        res.ovf = sum[acc_w] ^ sum[acc_w - 6'd1];
        if (!res.ovf) begin
            res.value = sum;
        end else if (sum[acc_w]) begin
            res.value = ~max_pos;
        end else begin
            res.value = max_pos;
        end
        return res;
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational sign-extend, add and optional saturate of one product into
// the running accumulator value.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SAT_EN = 1
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] raw;

    // One guard bit above ACC_W is enough: the sum of two ACC_W-range values
    // always fits in ACC_W+1 bits.
    assign raw = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};

    generate
        if (SAT_EN != 0) begin : g_sat
            sat_result_t res;
            logic        unused_hi;
            assign res       = saturate(sat_word_t'($signed(raw)), 6'(ACC_W));
            assign sum       = res.value[ACC_W-1:0];
            assign sat       = res.ovf;
            assign unused_hi = ^res.value[SAT_MAX_W-1:ACC_W];
        end else begin : g_wrap
            logic unused_msb;
            assign sum        = raw[ACC_W-1:0];
            assign sat        = 1'b0;
            assign unused_msb = raw[ACC_W];
        end
    endgenerate

endmodule

// File: rtl/booth_acc_stage.sv
// Frame accumulator behind the Booth multiplier: sums FRAME_LEN signed
// products and hands each frame total downstream over valid/ready.
module booth_acc_stage
    import booth_pkg::*;
#(
    parameter int PROD_W    = DEF_PROD_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAME_LEN = 4,
    parameter int SAT_EN    = 1,
    localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_prod_valid,
    input  logic [PROD_W-1:0] i_prod,
    output logic              o_prod_ready,
    input  logic              i_clear,
    output logic              o_acc_valid,
    output logic [ACC_W-1:0]  o_acc,
    input  logic              i_acc_ready,
    output logic              o_sat_flag,
    output logic [CNT_W-1:0]  o_count
);

    state_t             state_reg;
    state_t             state_next;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   result_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               sat_reg;

    logic [ACC_W-1:0]   add_sum;
    logic               add_sat;
    logic               accept;
    logic               last_prod;
    logic               out_hs;

    booth_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .SAT_EN (SAT_EN)
    ) u_sat_add (
        .acc  (acc_reg),
        .prod (i_prod),
        .sum  (add_sum),
        .sat  (add_sat)
    );

    // Ready is held low while reset is asserted so every output reads 0.
    assign o_prod_ready = (state_reg != OUT) && !i_rst;
    assign accept       = i_prod_valid && o_prod_ready && !i_clear;
    assign last_prod    = (count_reg == CNT_W'(FRAME_LEN - 1));
    assign out_hs       = (state_reg == OUT) && i_acc_ready;

    assign o_acc_valid  = (state_reg == OUT);
    assign o_acc        = result_reg;
    assign o_sat_flag   = sat_reg;
    assign o_count      = count_reg;

    always_comb begin
        state_next = state_reg;
        if (i_clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_next = last_prod ? OUT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept && last_prod) begin
                        state_next = OUT;
                    end
                end
                OUT: begin
                    if (i_acc_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // accept and out_hs never coincide: ready is low in OUT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_reg    <= '0;
            result_reg <= '0;
            count_reg  <= '0;
            sat_reg    <= 1'b0;
        end else if (i_clear || out_hs) begin
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (accept) begin
            acc_reg   <= add_sum;
            count_reg <= count_reg + CNT_W'(1);
            sat_reg   <= sat_reg | add_sat;
            if (last_prod) begin
                result_reg <= add_sum;
            end
        end
    end

endmodule

// File: tb/tb_booth_acc_stage.sv
// Scoreboard bench for booth_acc_stage: a default instance plus saturating
// and wrapping 8-bit instances fed from a shared stimulus.
module tb_booth_acc_stage;

    typedef struct {
        logic [15:0] acc;
        logic        sat;
    } exp16_t;

    typedef struct {
        logic [7:0] acc;
        logic       sat;
    } exp8_t;

    logic        clk;
    logic        rst;

    logic        prod_valid;
    logic [8:0]  prod;
    logic        prod_ready;
    logic        clear;
    logic        acc_valid;
    logic [15:0] acc;
    logic        acc_ready;
    logic        sat_flag;
    logic [2:0]  count;

    logic        v8;
    logic [7:0]  p8;
    logic        clr8;
    logic        rdy8;
    logic        s_ready, s_valid, s_sat;
    logic [7:0]  s_acc;
    logic [2:0]  s_count;
    logic        w_ready, w_valid, w_sat;
    logic [7:0]  w_acc;
    logic [2:0]  w_count;

    int checks;
    int errors;

    exp16_t q_main[$];
    exp8_t  q_sat[$];
    exp8_t  q_wrap[$];

    booth_acc_stage dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_prod_valid (prod_valid),
        .i_prod       (prod),
        .o_prod_ready (prod_ready),
        .i_clear      (clear),
        .o_acc_valid  (acc_valid),
        .o_acc        (acc),
        .i_acc_ready  (acc_ready),
        .o_sat_flag   (sat_flag),
        .o_count      (count)
    );

    booth_acc_stage #(.PROD_W(8), .ACC_W(8), .FRAME_LEN(4), .SAT_EN(1)) dut_sat (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_prod_valid (v8),
        .i_prod       (p8),
        .o_prod_ready (s_ready),
        .i_clear      (clr8),
        .o_acc_valid  (s_valid),
        .o_acc        (s_acc),
        .i_acc_ready  (rdy8),
        .o_sat_flag   (s_sat),
        .o_count      (s_count)
    );

    booth_acc_stage #(.PROD_W(8), .ACC_W(8), .FRAME_LEN(4), .SAT_EN(0)) dut_wrap (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_prod_valid (v8),
        .i_prod       (p8),
        .o_prod_ready (w_ready),
        .i_clear      (clr8),
        .o_acc_valid  (w_valid),
        .o_acc        (w_acc),
        .i_acc_ready  (rdy8),
        .o_sat_flag   (w_sat),
        .o_count      (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: one line per completed output handshake.
    always @(negedge clk) begin : mon_main
        exp16_t e;
        if (!rst && acc_valid && acc_ready) begin
            if (q_main.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected: got acc %h expected no result", acc);
            end else begin
                e = q_main.pop_front();
                $display("main result acc=%h sat=%b count=%0d", acc, sat_flag, count);
                chk("main_acc", 32'(acc), 32'(e.acc));
                chk("main_sat", 32'(sat_flag), 32'(e.sat));
                chk("main_count", 32'(count), 32'd4);
            end
        end
    end

    always @(negedge clk) begin : mon_sat
        exp8_t e;
        if (!rst && s_valid && rdy8) begin
            if (q_sat.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sat_unexpected: got acc %h expected no result", s_acc);
            end else begin
                e = q_sat.pop_front();
                $display("sat  result acc=%h sat=%b", s_acc, s_sat);
                chk("sat_acc", 32'(s_acc), 32'(e.acc));
                chk("sat_flag", 32'(s_sat), 32'(e.sat));
            end
        end
    end

    always @(negedge clk) begin : mon_wrap
        exp8_t e;
        if (!rst && w_valid && rdy8) begin
            if (q_wrap.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wrap_unexpected: got acc %h expected no result", w_acc);
            end else begin
                e = q_wrap.pop_front();
                $display("wrap result acc=%h sat=%b", w_acc, w_sat);
                chk("wrap_acc", 32'(w_acc), 32'(e.acc));
                chk("wrap_flag", 32'(w_sat), 32'(e.sat));
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [8:0] v);
        int guard;
        prod       = v;
        prod_valid = 1'b1;
        guard      = 0;
        @(negedge clk);
        while (!prod_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!prod_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready 0 expected 1");
        end
        @(posedge clk);
        #2;
        prod_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] v);
        int guard;
        p8    = v;
        v8    = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!(s_ready && w_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!(s_ready && w_ready)) begin
            checks++;
            errors++;
            $display("FAIL send8_timeout: got ready 0 expected 1");
        end
        @(posedge clk);
        #2;
        v8 = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [8:0] basic_vec [4];
        logic [8:0] bp_vec [4];
        basic_vec = '{9'h03F, 9'h1CF, 9'h03F, 9'h1CF};
        bp_vec    = '{9'd10, 9'd20, 9'd30, 9'd40};
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        prod_valid = 1'b0;
        prod       = '0;
        clear      = 1'b0;
        acc_ready  = 1'b1;
        v8         = 1'b0;
        p8         = '0;
        clr8       = 1'b0;
        rdy8       = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready_held", 32'(prod_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(prod_ready), 32'd1);
        chk("rst_valid", 32'(acc_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_sat", 32'(sat_flag), 32'd0);
        @(posedge clk);
        #2;

        // Basic frame: 63 - 49 + 63 - 49 = 28
        q_main.push_back('{16'h001C, 1'b0});
        for (int i = 0; i < 4; i++) begin
            send(basic_vec[i]);
            chk("basic_count", 32'(count), 32'(i + 1));
        end
        chk("basic_latency", 32'(acc_valid), 32'd1);
        @(posedge clk);
        #2;
        chk("basic_valid_drop", 32'(acc_valid), 32'd0);
        chk("basic_ready_back", 32'(prod_ready), 32'd1);
        chk("basic_count_zero", 32'(count), 32'd0);

        // Backpressure: 10+20+30+40 = 100 held while producer keeps offering
        acc_ready = 1'b0;
        q_main.push_back('{16'h0064, 1'b0});
        for (int i = 0; i < 4; i++) send(bp_vec[i]);
        prod_valid = 1'b1;
        prod       = 9'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_acc", 32'(acc), 32'h64);
            chk("bp_ready", 32'(prod_ready), 32'd0);
            chk("bp_valid", 32'(acc_valid), 32'd1);
            chk("bp_count", 32'(count), 32'd4);
        end
        @(posedge clk);
        #2;
        prod_valid = 1'b0;
        acc_ready  = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_release_valid", 32'(acc_valid), 32'd0);
        chk("bp_release_ready", 32'(prod_ready), 32'd1);
        q_main.push_back('{16'h0004, 1'b0});
        for (int i = 0; i < 4; i++) send(9'd1);
        @(posedge clk);
        #2;

        // Clear mid-frame; product offered alongside clear is dropped
        send(9'd5);
        send(9'd6);
        chk("clr_pre_count", 32'(count), 32'd2);
        clear      = 1'b1;
        prod_valid = 1'b1;
        prod       = 9'd100;
        @(posedge clk);
        #2;
        clear      = 1'b0;
        prod_valid = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_valid", 32'(acc_valid), 32'd0);
        chk("clr_ready", 32'(prod_ready), 32'd1);
        q_main.push_back('{16'h0008, 1'b0});
        for (int i = 0; i < 4; i++) send(9'd2);
        @(posedge clk);
        #2;

        // 8-bit saturating vs wrapping instances
        q_sat.push_back('{8'h7F, 1'b1});
        q_wrap.push_back('{8'hC8, 1'b0});
        send8(8'd100);
        send8(8'd100);
        send8(8'd0);
        send8(8'd0);
        @(posedge clk);
        #2;
        q_sat.push_back('{8'h85, 1'b1});
        q_wrap.push_back('{8'h3D, 1'b0});
        send8(8'h9C);
        send8(8'h9C);
        send8(8'd5);
        send8(8'd0);
        @(posedge clk);
        #2;

        // Asynchronous reset mid-frame
        send(9'd3);
        send(9'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_acc", 32'(acc), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(acc_valid), 32'd0);
        chk("arst_sat", 32'(sat_flag), 32'd0);
        chk("arst_ready", 32'(prod_ready), 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("arst_ready_back", 32'(prod_ready), 32'd1);
        chk("arst_count_idle", 32'(count), 32'd0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_main_empty", 32'(q_main.size()), 32'd0);
        chk("sb_sat_empty", 32'(q_sat.size()), 32'd0);
        chk("sb_wrap_empty", 32'(q_wrap.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_acc_stage.md
Name: booth_acc_stage

Overview:
Downstream consumer of the Booth multiplier product stream.
Accepts signed products over a valid/ready handshake and accumulates a fixed-length frame of FRAME_LEN products into a wider accumulator, with optional saturation.
Presents each completed frame sum on a valid/ready output port, then starts the next frame.
Sits between booth_algo's product output and the result sink or register file.

Parameters:
PROD_W, 9, product width; two's-complement signed; matches the multiplier output width.
ACC_W, 16, accumulator and result width; two's-complement signed; must satisfy ACC_W >= PROD_W.
FRAME_LEN, 4, number of products summed per frame; must be >= 1.
SAT_EN, 1, 1 = clamp the sum to the ACC_W signed range; 0 = wrap modulo 2^ACC_W.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_prod_valid  in  1  a product is present on i_prod.
i_prod  in  PROD_W  signed product from the multiplier.
o_prod_ready  out  1  stage can accept a product.
i_clear  in  1  synchronous frame abort.
o_acc_valid  out  1  a frame result is present on o_acc.
o_acc  out  ACC_W  signed frame sum.
i_acc_ready  in  1  downstream accepts the result.
o_sat_flag  out  1  saturation occurred in the presented frame.
o_count  out  $clog2(FRAME_LEN+1)  number of products accepted in the current frame.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state = IDLE; accumulator, o_acc, o_count and o_sat_flag = 0; o_acc_valid = 0; o_prod_ready = 1 once i_rst deasserts.
- States:
  - IDLE: no products accepted yet in the frame.
  - ACCUM: 1 to FRAME_LEN-1 products accepted.
  - OUT: result is being presented.
- Transitions:
  - IDLE -> ACCUM on the first accept.
  - ACCUM -> OUT on the FRAME_LEN-th accept.
  - When FRAME_LEN = 1: IDLE -> OUT directly.
  - OUT -> IDLE on output handshake (o_acc_valid & i_acc_ready).
- Input handshake:
  - Accept when i_prod_valid & o_prod_ready.
  - o_prod_ready = 1 in IDLE and ACCUM, 0 in OUT.
  - o_prod_ready returns to 1 the cycle after the output handshake. There is no same-cycle bypass.
  - i_prod_valid while o_prod_ready = 0 is ignored; the producer must hold the product.
- Arithmetic:
  - Sign-extend i_prod to ACC_W+1 bits and add to the sign-extended accumulator.
  - SAT_EN = 1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] at every add; any clamp sets o_sat_flag (sticky within the frame).
  - SAT_EN = 0: take the low ACC_W bits; o_sat_flag stays 0.
- Latency:
  - o_acc_valid rises the cycle after the FRAME_LEN-th accept.
  - o_acc holds the registered final sum, including that product.
- Output hold:
  - While o_acc_valid = 1 and i_acc_ready = 0, o_acc, o_sat_flag and o_acc_valid stay stable.
- Output handshake:
  - Next cycle: accumulator = 0, o_count = 0, o_sat_flag = 0, o_acc_valid = 0.
  - o_acc may retain its last value.
- o_count:
  - Increments on each accept; equals FRAME_LEN in OUT; resets to 0 on return to IDLE.
- i_clear (priority below reset, above all else):
  - Next edge: state = IDLE, accumulator, o_count and o_sat_flag = 0, o_acc_valid = 0. A pending result is dropped.
  - A product offered in the same cycle as i_clear is not accepted, even though o_prod_ready may read 1.
- i_acc_ready high while o_acc_valid = 0: no effect.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE, ACCUM, OUT).
  - default PROD_W/ACC_W constants shared with booth_algo.
  - saturate function (ACC_W+1 bits -> ACC_W bits plus overflow bit).
- Sub-module booth_sat_add: combinational sign-extend, add and saturate, parameterised by PROD_W, ACC_W and SAT_EN. It is the natural split; the FSM and handshake stay in booth_acc_stage.

Test Plan:
- Basic frame (defaults): products +63 (9'h03F), -49 (9'h1CF), +63, -49, with i_acc_ready = 1 -> o_acc_valid pulses one cycle after the 4th accept, o_acc = 16'h001C, o_sat_flag = 0, then o_prod_ready = 1.
- Positive saturation (ACC_W = 8, SAT_EN = 1): products 100, 100, 0, 0 -> o_acc = 8'h7F, o_sat_flag = 1.
- Negative saturation (same instance): products -100, -100, 5, 0 -> o_acc = 8'h85 (-128+5), o_sat_flag = 1.
- Wrap mode (ACC_W = 8, SAT_EN = 0): products 100, 100, 0, 0 -> o_acc = 8'hC8, o_sat_flag = 0.
- Backpressure: hold i_acc_ready = 0 for 5 cycles after o_acc_valid rises while driving i_prod_valid = 1 -> o_acc stable, o_prod_ready = 0, no extra accepts. On release: one handshake, then 4 new products of +1 give 16'h0004.
- Clear and reset mid-frame:
  - Accept 2 products, assert i_clear one cycle -> o_count = 0; a following frame of four +2 gives 16'h0008.
  - Assert i_rst asynchronously mid-frame -> all outputs 0 before the next clock edge.
